// File: rtl/fp_hs_pkg.sv
// Shared types and defaults for the double-precision stb/ack operand protocol.
// Used by the initiator and by the core-side responders.
package fp_hs_pkg;

  typedef logic [63:0] fp64_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_Z,
    RESP
  } init_state_e;

  localparam int unsigned DEFAULT_TAG_W   = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/fp_stb_initiator_if.sv
// Bundle of the upstream request, core stb/ack and downstream result channels.
// master = the initiator block, slave = the surrounding control/core side.
interface fp_stb_initiator_if
  import fp_hs_pkg::*;
#(
  parameter int unsigned TAG_W = DEFAULT_TAG_W
) ();

  logic             req_valid;
  logic             req_ready;
  fp64_t            req_a;
  fp64_t            req_b;
  logic [TAG_W-1:0] req_tag;

  fp64_t            input_a;
  fp64_t            input_b;
  logic             input_a_stb;
  logic             input_b_stb;
  logic             input_a_ack;
  logic             input_b_ack;

  fp64_t            output_z;
  logic             output_z_stb;
  logic             output_z_ack;

  logic             res_valid;
  logic             res_ready;
  fp64_t            res_z;
  logic [TAG_W-1:0] res_tag;

  logic [31:0]      op_count;
  logic             timeout;

  modport master (
    input  req_valid, req_a, req_b, req_tag,
    input  input_a_ack, input_b_ack,
    input  output_z, output_z_stb,
    input  res_ready,
    output req_ready,
    output input_a, input_b, input_a_stb, input_b_stb,
    output output_z_ack,
    output res_valid, res_z, res_tag,
    output op_count, timeout
  );

  modport slave (
    output req_valid, req_a, req_b, req_tag,
    output input_a_ack, input_b_ack,
    output output_z, output_z_stb,
    output res_ready,
    input  req_ready,
    input  input_a, input_b, input_a_stb, input_b_stb,
    input  output_z_ack,
    input  res_valid, res_z, res_tag,
    input  op_count, timeout
  );

endinterface

// File: rtl/fp_stb_initiator_watchdog.sv
// Saturating stall counter with a sticky expiry flag; cleared on each new wait,
// advanced on every waiting cycle that did not complete.
module fp_hs_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        expired_q, expired_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      // cnt_q counts elapsed stalled cycles; this edge completes cycle cnt_q+1
      if (cnt_q == 16'(TIMEOUT - 1)) expired_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/fp_stb_initiator.sv
// Initiator for the FP-core stb/ack protocol: takes one operand pair over
// valid/ready, issues A/B independently, collects Z and returns it tagged.
module fp_stb_initiator
  import fp_hs_pkg::*;
#(
  parameter int unsigned TAG_W   = DEFAULT_TAG_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst_n,
  fp_stb_initiator_if.master  bus
);

  init_state_e      state_q;
  logic             ready_q;
  logic             a_stb_q;
  logic             b_stb_q;
  logic             z_ack_q;
  logic             res_valid_q;
  fp64_t            a_q;
  fp64_t            b_q;
  fp64_t            res_z_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      op_count_q;

  logic a_done;
  logic b_done;
  logic issue_done;
  logic z_xfer;
  logic timeout_w;

  assign a_done     = a_stb_q & bus.input_a_ack;
  assign b_done     = b_stb_q & bus.input_b_ack;
  // A channel whose strobe is already low finished on an earlier edge
  assign issue_done = (state_q == ISSUE) && (a_done || !a_stb_q) && (b_done || !b_stb_q);
  assign z_xfer     = z_ack_q & bus.output_z_stb;

  fp_hs_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (issue_done),
    .run_i     ((state_q == WAIT_Z) && !z_xfer),
    .expired_o (timeout_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      res_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_z_q     <= '0;
      tag_q       <= '0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // ready rises one edge after reset release, so no capture on that edge
          ready_q <= 1'b1;
          if (ready_q && bus.req_valid) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            tag_q   <= bus.req_tag;
            a_stb_q <= 1'b1;
            b_stb_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (a_done) a_stb_q <= 1'b0;
          if (b_done) b_stb_q <= 1'b0;
          if (issue_done) begin
            z_ack_q <= 1'b1;
            state_q <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (z_xfer) begin
            res_z_q     <= bus.output_z;
            z_ack_q     <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            op_count_q  <= op_count_q + 32'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.input_a      = a_q;
  assign bus.input_b      = b_q;
  assign bus.input_a_stb  = a_stb_q;
  assign bus.input_b_stb  = b_stb_q;
  assign bus.output_z_ack = z_ack_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_z        = res_z_q;
  assign bus.res_tag      = tag_q;
  assign bus.op_count     = op_count_q;
  assign bus.timeout      = timeout_w;

endmodule
